// File: rtl/bpi_arbiter_if.sv
// Interfaces between bpi_arbiter, its two requesters and the shared bpi_interface.
//   bpi_req_if   : one requester session (REQ/GNT) plus its flash command and status.
//                  master = requester side, slave = arbiter side.
//   bpi_flash_if : the single bpi_interface command port.
//                  master = arbiter side, slave = bpi_interface side.
//                  DATA_FROM is broadcast to both requesters outside the arbiter.

interface bpi_req_if;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;

    logic              REQ;
    logic              GNT;
    logic [OP_W-1:0]   OP;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_TO;
    logic              EXECUTE;
    logic              BUSY;
    logic              LOAD_DATA;
    logic              TMO;

    modport master (
        output REQ, OP, ADDR, DATA_TO, EXECUTE,
        input  GNT, BUSY, LOAD_DATA, TMO
    );

    modport slave (
        input  REQ, OP, ADDR, DATA_TO, EXECUTE,
        output GNT, BUSY, LOAD_DATA, TMO
    );
endinterface

interface bpi_flash_if;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;

    logic [OP_W-1:0]   OP;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_TO;
    logic              EXECUTE;
    logic              BUSY;
    logic              LOAD_DATA;
    logic [DATA_W-1:0] DATA_FROM;

    modport master (
        output OP, ADDR, DATA_TO, EXECUTE,
        input  BUSY, LOAD_DATA
    );

    modport slave (
        input  OP, ADDR, DATA_TO, EXECUTE,
        output BUSY, LOAD_DATA, DATA_FROM
    );
endinterface

// File: rtl/bpi_arbiter.sv
// bpi_arbiter: shares one bpi_interface command port between requester A (JTAG
// BPI_ctrl) and requester B (fabric client). Per-session REQ/GNT, round-robin on
// ties, switching only while the flash is idle, idle-grant watchdog.
// Ports:
//   CLK, RST  : clock and synchronous active-high reset
//   a_if, b_if: requester sessions (slave side)
//   bpi       : shared bpi_interface command port (master side)
//   OWNER     : current state code (00 idle, 01 A, 10 B, 11 drain)

module bpi_arbiter #(
    parameter logic [15:0] TIMEOUT   = 16'd40000,
    parameter logic        FIRST_PRI = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    bpi_req_if.slave          a_if,
    bpi_req_if.slave          b_if,
    bpi_flash_if.master       bpi,
    output logic [1:0]        OWNER
);

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WDOG_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10,
        DRAIN = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                rr_q, rr_d;
    logic                a_tmo_q, a_tmo_d;
    logic                b_tmo_q, b_tmo_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                gnt_a, gnt_b;
    logic                own_exec;
    logic                idle_cyc;
    logic                wdog_fire;

    assign gnt_a = (state_q == GNT_A);
    assign gnt_b = (state_q == GNT_B);

    // Watchdog sees only the owning requester's activity
    always_comb begin
        own_exec = 1'b0;
        if (gnt_a) begin
            own_exec = a_if.EXECUTE;
        end else if (gnt_b) begin
            own_exec = b_if.EXECUTE;
        end
    end

    assign idle_cyc  = !bpi.BUSY && !own_exec;
    assign wdog_fire = (TIMEOUT != 16'd0) && idle_cyc &&
                       (wdog_q == WDOG_W'(TIMEOUT - 16'd1));

    // Next-state, round-robin pointer, timeout flags and hold registers
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // A sticky timeout flag clears once its REQ is seen low
        a_tmo_d = a_tmo_q && a_if.REQ;
        b_tmo_d = b_tmo_q && b_if.REQ;
        wdog_d  = wdog_q;

        unique case (state_q)
            IDLE: begin
                if (!bpi.BUSY) begin
                    if (a_if.REQ && b_if.REQ) begin
                        state_d = rr_q ? GNT_B : GNT_A;
                        rr_d    = !rr_q;
                    end else if (a_if.REQ) begin
                        state_d = GNT_A;
                    end else if (b_if.REQ) begin
                        state_d = GNT_B;
                    end
                end
            end
            GNT_A: begin
                addr_d = a_if.ADDR;
                data_d = a_if.DATA_TO;
                // A released session wins over a coincident timeout
                if (!a_if.REQ) begin
                    state_d = DRAIN;
                end else if (wdog_fire) begin
                    state_d = DRAIN;
                    a_tmo_d = 1'b1;
                end
            end
            GNT_B: begin
                addr_d = b_if.ADDR;
                data_d = b_if.DATA_TO;
                if (!b_if.REQ) begin
                    state_d = DRAIN;
                end else if (wdog_fire) begin
                    state_d = DRAIN;
                    b_tmo_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!bpi.BUSY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts granted idle cycles; saturates rather than wrapping
        if ((state_d != state_q) || !(gnt_a || gnt_b) || !idle_cyc) begin
            wdog_d = '0;
        end else if (wdog_q != 16'hFFFF) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            wdog_q  <= '0;
            rr_q    <= FIRST_PRI;
            a_tmo_q <= 1'b0;
            b_tmo_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            rr_q    <= rr_d;
            a_tmo_q <= a_tmo_d;
            b_tmo_q <= b_tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Zero-latency command mux; address/data hold their last values when unowned
    always_comb begin
        bpi.OP      = 2'b00;
        bpi.EXECUTE = 1'b0;
        bpi.ADDR    = addr_q;
        bpi.DATA_TO = data_q;
        if (gnt_a) begin
            bpi.OP      = a_if.OP;
            bpi.EXECUTE = a_if.EXECUTE;
            bpi.ADDR    = a_if.ADDR;
            bpi.DATA_TO = a_if.DATA_TO;
        end else if (gnt_b) begin
            bpi.OP      = b_if.OP;
            bpi.EXECUTE = b_if.EXECUTE;
            bpi.ADDR    = b_if.ADDR;
            bpi.DATA_TO = b_if.DATA_TO;
        end
    end

    // Status back to requesters; a non-owner always sees a busy flash
    assign a_if.GNT       = gnt_a;
    assign a_if.BUSY      = gnt_a ? bpi.BUSY : 1'b1;
    assign a_if.LOAD_DATA = gnt_a && bpi.LOAD_DATA;
    assign a_if.TMO       = a_tmo_q;

    assign b_if.GNT       = gnt_b;
    assign b_if.BUSY      = gnt_b ? bpi.BUSY : 1'b1;
    assign b_if.LOAD_DATA = gnt_b && bpi.LOAD_DATA;
    assign b_if.TMO       = b_tmo_q;

    assign OWNER = state_q;

endmodule

// File: tb/tb_bpi_arbiter.sv
// Self-checking bench for bpi_arbiter (TIMEOUT = 100, FIRST_PRI = 0).
// Inputs change on the falling edge; outputs are sampled 2 ns later, before the
// next rising edge, so each vector describes one clock cycle.

module tb_bpi_arbiter;

    localparam logic [22:0] AA = 23'h012345;
    localparam logic [22:0] BA = 23'h7ABCDE;

    typedef struct packed {
        logic        rst;
        logic        a_req;
        logic        b_req;
        logic [1:0]  a_op;
        logic [22:0] a_addr;
        logic        a_exec;
        logic        b_exec;
        logic        busy;
        logic        load;
    } in_t;

    typedef struct packed {
        logic [1:0]  owner;
        logic        a_gnt;
        logic        b_gnt;
        logic [1:0]  op;
        logic        exec;
        logic [22:0] addr;
        logic        a_busy;
        logic        b_busy;
        logic        a_load;
        logic        b_load;
        logic        a_tmo;
        logic        b_tmo;
    } exp_t;

    typedef struct {
        string name;
        in_t   i;
        exp_t  e;
    } vec_t;

    logic clk;
    logic rst;
    logic [1:0] owner;

    bpi_req_if   a_if ();
    bpi_req_if   b_if ();
    bpi_flash_if bpi ();

    bpi_arbiter #(
        .TIMEOUT   (16'd100),
        .FIRST_PRI (1'b0)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .a_if  (a_if),
        .b_if  (b_if),
        .bpi   (bpi),
        .OWNER (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    exp_t  exp_q[$];
    string name_q[$];
    vec_t  tbl[$];

    function automatic vec_t mk(
        input string n,
        input logic r, input logic ar, input logic br, input logic [1:0] aop,
        input logic [22:0] aad, input logic ax, input logic bx, input logic bsy, input logic ld,
        input logic [1:0] own, input logic ag, input logic bg, input logic [1:0] op,
        input logic ex, input logic [22:0] ad, input logic ab, input logic bb,
        input logic al, input logic bl, input logic at, input logic bt);
        vec_t v;
        v.name = n;
        v.i = '{rst: r, a_req: ar, b_req: br, a_op: aop, a_addr: aad, a_exec: ax,
                b_exec: bx, busy: bsy, load: ld};
        v.e = '{owner: own, a_gnt: ag, b_gnt: bg, op: op, exec: ex, addr: ad,
                a_busy: ab, b_busy: bb, a_load: al, b_load: bl, a_tmo: at, b_tmo: bt};
        return v;
    endfunction

    task automatic check_front();
        exp_t  e;
        exp_t  a;
        string n;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = '{owner: owner, a_gnt: a_if.GNT, b_gnt: b_if.GNT, op: bpi.OP,
              exec: bpi.EXECUTE, addr: bpi.ADDR, a_busy: a_if.BUSY, b_busy: b_if.BUSY,
              a_load: a_if.LOAD_DATA, b_load: b_if.LOAD_DATA, a_tmo: a_if.TMO, b_tmo: b_if.TMO};
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s @%0t: got owner=%b gnt=%b%b op=%b ex=%b addr=%h busy=%b%b load=%b%b tmo=%b%b, want owner=%b gnt=%b%b op=%b ex=%b addr=%h busy=%b%b load=%b%b tmo=%b%b",
                     n, $time, a.owner, a.a_gnt, a.b_gnt, a.op, a.exec, a.addr, a.a_busy, a.b_busy,
                     a.a_load, a.b_load, a.a_tmo, a.b_tmo, e.owner, e.a_gnt, e.b_gnt, e.op, e.exec,
                     e.addr, e.a_busy, e.b_busy, e.a_load, e.b_load, e.a_tmo, e.b_tmo);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst            = v.i.rst;
        a_if.REQ       = v.i.a_req;
        b_if.REQ       = v.i.b_req;
        a_if.OP        = v.i.a_op;
        a_if.ADDR      = v.i.a_addr;
        a_if.EXECUTE   = v.i.a_exec;
        b_if.EXECUTE   = v.i.b_exec;
        bpi.BUSY       = v.i.busy;
        bpi.LOAD_DATA  = v.i.load;
        exp_q.push_back(v.e);
        name_q.push_back(v.name);
        #2;
        check_front();
    endtask

    initial begin
        rst           = 1'b1;
        a_if.REQ      = 1'b0;
        a_if.OP       = 2'b00;
        a_if.ADDR     = '0;
        a_if.DATA_TO  = 16'hA5A5;
        a_if.EXECUTE  = 1'b0;
        b_if.REQ      = 1'b0;
        b_if.OP       = 2'b01;
        b_if.ADDR     = BA;
        b_if.DATA_TO  = 16'h5A5A;
        b_if.EXECUTE  = 1'b0;
        bpi.BUSY      = 1'b0;
        bpi.LOAD_DATA = 1'b0;
        bpi.DATA_FROM = 16'h1234;
        repeat (2) @(posedge clk);

        // name, rst,areq,breq,aop,aaddr,aex,bex,busy,ld | own,ag,bg,op,ex,addr,ab,bb,al,bl,at,bt
        tbl.push_back(mk("reset_state",      1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,  1,1,0,0,0,0));
        tbl.push_back(mk("a_req_idle",       0,1,0,2,AA,0,0,0,0, 0,0,0,0,0,0,  1,1,0,0,0,0));
        tbl.push_back(mk("a_granted",        0,1,0,2,AA,0,0,0,0, 1,1,0,2,0,AA, 0,1,0,0,0,0));
        tbl.push_back(mk("a_exec_fwd",       0,1,0,2,AA,1,0,0,0, 1,1,0,2,1,AA, 0,1,0,0,0,0));
        tbl.push_back(mk("a_load_b_exec",    0,1,0,2,AA,0,1,1,1, 1,1,0,2,0,AA, 1,1,1,0,0,0));
        tbl.push_back(mk("b_exec_ignored",   0,1,1,2,AA,0,1,0,0, 1,1,0,2,0,AA, 0,1,0,0,0,0));
        tbl.push_back(mk("a_drop_busy",      0,0,1,2,AA,0,0,1,0, 1,1,0,2,0,AA, 1,1,0,0,0,0));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk("drain_busy",   0,0,1,0,0, 0,0,1,0, 3,0,0,0,0,AA, 1,1,0,0,0,0));
        tbl.push_back(mk("drain_free",       0,0,1,0,0, 0,0,0,0, 3,0,0,0,0,AA, 1,1,0,0,0,0));
        tbl.push_back(mk("idle_to_b",        0,0,1,0,0, 0,0,0,0, 0,0,0,0,0,AA, 1,1,0,0,0,0));
        tbl.push_back(mk("b_granted_exec",   0,0,1,0,0, 0,1,0,0, 2,0,1,1,1,BA, 1,0,0,0,0,0));
        tbl.push_back(mk("b_drop",           0,0,0,0,0, 0,0,0,0, 2,0,1,1,0,BA, 1,0,0,0,0,0));
        tbl.push_back(mk("drain_min",        0,0,0,0,0, 0,0,0,0, 3,0,0,0,0,BA, 1,1,0,0,0,0));
        tbl.push_back(mk("tie_idle",         0,1,1,1,AA,0,0,0,0, 0,0,0,0,0,BA, 1,1,0,0,0,0));
        tbl.push_back(mk("a_drop_with_exec", 0,0,1,1,AA,1,0,0,0, 1,1,0,1,1,AA, 0,1,0,0,0,0));
        tbl.push_back(mk("drain_after_exec", 0,0,1,0,0, 0,0,1,0, 3,0,0,0,0,AA, 1,1,0,0,0,0));
        tbl.push_back(mk("drain_exit",       0,1,1,0,0, 0,0,0,0, 3,0,0,0,0,AA, 1,1,0,0,0,0));
        tbl.push_back(mk("tie2_idle",        0,1,1,0,0, 0,0,0,0, 0,0,0,0,0,AA, 1,1,0,0,0,0));
        tbl.push_back(mk("tie2_b_wins",      0,1,1,0,0, 0,0,0,0, 2,0,1,1,0,BA, 1,0,0,0,0,0));
        tbl.push_back(mk("rst_in_gnt_b",     1,0,1,0,0, 0,0,1,0, 2,0,1,1,0,BA, 1,1,0,0,0,0));
        tbl.push_back(mk("rst_idle_busy",    0,0,1,0,0, 0,0,1,0, 0,0,0,0,0,0,  1,1,0,0,0,0));
        tbl.push_back(mk("idle_hold_busy",   0,0,1,0,0, 0,0,1,0, 0,0,0,0,0,0,  1,1,0,0,0,0));
        tbl.push_back(mk("idle_busy_free",   0,0,1,0,0, 0,0,0,0, 0,0,0,0,0,0,  1,1,0,0,0,0));
        tbl.push_back(mk("b_regrant",        0,0,0,0,0, 0,0,0,0, 2,0,1,1,0,BA, 1,0,0,0,0,0));
        tbl.push_back(mk("b_regrant_drain",  0,0,0,0,0, 0,0,0,0, 3,0,0,0,0,BA, 1,1,0,0,0,0));

        foreach (tbl[k]) step(tbl[k]);

        // Watchdog: A idle for exactly 100 granted cycles, B pending from cycle 50
        step(mk("tmo_req",                   0,1,0,0,0, 0,0,0,0, 0,0,0,0,0,BA, 1,1,0,0,0,0));
        for (int k = 1; k <= 100; k++) begin
            logic br;
            br = (k >= 50);
            step(mk("tmo_idle",              0,1,br,0,0,0,0,0,0, 1,1,0,0,0,0,  0,1,0,0,0,0));
        end
        step(mk("tmo_fired",                 0,0,1,0,0, 0,0,0,0, 3,0,0,0,0,0,  1,1,0,0,1,0));
        step(mk("tmo_cleared",               0,0,1,0,0, 0,0,0,0, 0,0,0,0,0,0,  1,1,0,0,0,0));
        step(mk("b_after_tmo",               0,0,0,0,0, 0,0,0,0, 2,0,1,1,0,BA, 1,0,0,0,0,0));
        step(mk("b_after_tmo_drain",         0,0,0,0,0, 0,0,0,0, 3,0,0,0,0,BA, 1,1,0,0,0,0));

        // REQ falling in the cycle the watchdog would fire: drain without TMO
        step(mk("race_req",                  0,1,0,0,0, 0,0,0,0, 0,0,0,0,0,BA, 1,1,0,0,0,0));
        for (int k = 1; k <= 99; k++)
            step(mk("race_idle",             0,1,0,0,0, 0,0,0,0, 1,1,0,0,0,0,  0,1,0,0,0,0));
        step(mk("race_drop",                 0,0,0,0,0, 0,0,0,0, 1,1,0,0,0,0,  0,1,0,0,0,0));
        step(mk("race_no_tmo",               0,0,0,0,0, 0,0,0,0, 3,0,0,0,0,0,  1,1,0,0,0,0));
        step(mk("race_idle_after",           0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,  1,1,0,0,0,0));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
